// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, address-width helper and index type for regfile_mp
package regfile_pkg;

    localparam int REG_WIDTH_DEF = 16;
    localparam int REG_DEPTH_DEF = 16;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int REG_AW_DEF = addr_w(REG_DEPTH_DEF);

    typedef logic [REG_AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_word.sv
// rtl/regfile_word.sv - one storage word with async active-low clear and write enable
module regfile_word
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // word storage: cleared by reset, loaded when this word is the write target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; optional macro REGFILE_BYPASS_EN
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH_DEF,
    parameter int DEPTH  = REG_DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int AW     = addr_w(DEPTH)
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    output logic [NUM_RD-1:0]       rd_busy,
    output logic                    any_busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:0] busy_vec;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rdat;
    logic             rbusy;

    // register 0 reads as zero and has no storage
    assign mem[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_word
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk (clk),
                .rst (rst),
                .we  (wr_en && (wr_addr == AW'(gi))),
                .d   (wr_data),
                .q   (mem[gi])
            );
        end
    endgenerate

    // scoreboard: reserve sets, write clears; reserve wins on a same-address collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (rsv_en && (rsv_addr == AW'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_en && (wr_addr == AW'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // register 0 is never busy
    assign busy_vec = {busy_q, 1'b0};
    assign any_busy = |busy_q;

    // combinational read muxes; a disabled port drives zero data and zero busy
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        rbusy   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra    = rd_addr[p*AW +: AW];
            rdat  = mem[ra];
            rbusy = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
            // forward the in-flight write; it retires the pending producer unless re-reserved
            if (wr_en && (wr_addr == ra) && (ra != '0)) begin
                rdat  = wr_data;
                rbusy = rsv_en && (rsv_addr == ra);
            end
`endif
            if (rd_en[p]) begin
                rd_data[p*WIDTH +: WIDTH] = rdat;
                rd_busy[p]                = rbusy;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp against an array model
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [1:0]  rd_busy;
    logic        any_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl_mem  [16];
    bit          mdl_busy [16];

    regfile_mp #(.WIDTH(16), .DEPTH(16), .NUM_RD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit we, input int wa, input int wd, input bit [1:0] ren,
                         input int a0, input int a1, input bit rs, input int ra);
        wr_en    = we;
        wr_addr  = 4'(wa);
        wr_data  = 16'(wd);
        rd_en    = ren;
        rd_addr  = {4'(a1), 4'(a0)};
        rsv_en   = rs;
        rsv_addr = 4'(ra);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    // expected outputs for the currently driven inputs and current model state
    task automatic check_model(input string tag);
        logic [31:0] ed;
        logic [1:0]  eb;
        bit          anyb;
        int          a;
        logic [15:0] d;
        bit          b;
        ed   = '0;
        eb   = '0;
        anyb = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a = int'(rd_addr[p*4 +: 4]);
            d = mdl_mem[a];
            b = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && int'(wr_addr) == a && a != 0) begin
                d = wr_data;
                b = rsv_en && int'(rsv_addr) == a;
            end
`endif
            if (rd_en[p]) begin
                ed[p*16 +: 16] = d;
                eb[p]          = b;
            end
        end
        for (int i = 0; i < 16; i++) anyb |= mdl_busy[i];
        check({tag, "_data"}, rd_data, ed);
        check({tag, "_busy"}, 32'(rd_busy), 32'(eb));
        check({tag, "_any"}, 32'(any_busy), 32'(anyb));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (wr_en && wr_addr != 0) begin
                mdl_mem[wr_addr]  = wr_data;
                mdl_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) mdl_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 2'b11, 5, 15, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", rd_data, 32'h0);
        check("rst_busy", 32'(rd_busy), 32'h0);
        check("rst_any", 32'(any_busy), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 2'b11, i, 15 - i, 0, 0);
            #2;
            check("init_data", rd_data, 32'h0);
            check("init_busy", 32'(rd_busy), 32'h0);
            check("init_any", 32'(any_busy), 32'h0);
            tick();
        end

        drive(1, 5, 16'hA5A5, 2'b11, 5, 15, 0, 0);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r5", 32'(rd_data[15:0]), 32'hA5A5);
`endif
        check_model("wr5");
        tick();
        drive(1, 15, 16'hFFFF, 2'b11, 5, 15, 0, 0);
        #2;
        check_model("wr15");
        tick();
        drive(0, 0, 0, 2'b11, 5, 15, 0, 0);
        #2;
        check("wr_rd", rd_data, 32'hFFFF_A5A5);
        check_model("wr_rd");
        tick();

        drive(1, 0, 16'h1234, 2'b01, 0, 0, 1, 0);
        #2;
        check_model("r0_wr");
        tick();
        drive(0, 0, 0, 2'b01, 0, 0, 0, 0);
        #2;
        check("r0_data", rd_data, 32'h0);
        check("r0_busy", 32'(rd_busy), 32'h0);
        check("r0_any", 32'(any_busy), 32'h0);
        tick();

        drive(0, 0, 0, 2'b11, 3, 3, 1, 3);
        #2;
        check("rsv3_same_cycle", 32'(rd_busy), 32'h0);
        tick();
        drive(0, 0, 0, 2'b11, 3, 3, 0, 0);
        #2;
        check("r3_busy", 32'(rd_busy), 32'h3);
        check("r3_any", 32'(any_busy), 32'h1);
        tick();
        drive(1, 3, 16'h0042, 2'b11, 3, 3, 0, 0);
        #2;
        check_model("wr3");
        tick();
        drive(0, 0, 0, 2'b11, 3, 3, 0, 0);
        #2;
        check("r3_clr_busy", 32'(rd_busy), 32'h0);
        check("r3_data", rd_data, 32'h0042_0042);
        tick();
        drive(0, 0, 0, 2'b00, 0, 0, 1, 3);
        tick();
        drive(0, 0, 0, 2'b01, 3, 3, 0, 0);
        #2;
        check("rden_data", rd_data, 32'h0000_0042);
        check("rden_busy", 32'(rd_busy), 32'h1);
        tick();

        drive(1, 7, 16'hBEEF, 2'b00, 0, 0, 1, 7);
        tick();
        drive(0, 0, 0, 2'b11, 7, 7, 0, 0);
        #2;
        check("r7_data", rd_data, 32'hBEEF_BEEF);
        check("r7_busy", 32'(rd_busy), 32'h3);
        tick();

        for (int n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            #2;
            check_model("rand");
            tick();
        end

        drive(1, 4, 16'h00FF, 2'b00, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 2'b00, 0, 0, 1, 4);
        tick();
        drive(1, 9, 16'h1111, 2'b11, 4, 4, 0, 0);
        #2;
        check("pre_rst_data", rd_data, 32'h00FF_00FF);
        check("pre_rst_busy", 32'(rd_busy), 32'h3);
        rst = 1'b0;
        #1;
        check("async_data", rd_data, 32'h0);
        check("async_busy", 32'(rd_busy), 32'h0);
        check("async_any", 32'(any_busy), 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 2'b11, 9, 4, 0, 0);
        #2;
        check("lost_wr", rd_data, 32'h0);
        check_model("post_rst");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
